serial_alu_seq: RTL

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/serial_alu_seq_pkg.sv | 28 ++
 rtl/serial_alu_seq_fa.sv | 13 +
 rtl/serial_alu_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM states, default width,
// and the operand-preparation rules applied when an operation is latched.
package serial_alu_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // SUB and NEG add the one's complement of B plus an initial carry of 1.
    function automatic logic invert_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_NEG);
    endfunction

    // NEG and PASS use zero as the A operand.
    function automatic logic zero_a(input logic [1:0] op);
        return (op == OP_NEG) || (op == OP_PASS);
    endfunction

endpackage

// File: rtl/serial_alu_seq_fa.sv
// Single-bit full adder used as the one arithmetic slice of the serial ALU.
module FullAdder (
    input  logic io_a,
    input  logic io_b,
    input  logic io_cin,
    output logic io_sum,
    output logic io_cout
);

    assign io_sum  = io_a ^ io_b ^ io_cin;
    assign io_cout = (io_a & io_b) | (io_cin & (io_a ^ io_b));

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ADD/SUB/NEG/PASS unit: one full adder processes one bit per clock, LSB first,
// so an operation takes WIDTH cycles in RUN plus one DONE cycle.
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic [1:0]       io_op,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic             io_busy,
    output logic             io_done,
    output logic [WIDTH-1:0] io_result,
    output logic             io_cout,
    output logic             io_neg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, result_reg;
    logic [WIDTH-1:0] sum_shifted;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg;
    logic             fa_sum, fa_cout;
    logic             last_bit;

    FullAdder u_fa (
        .io_a   (a_reg[0]),
        .io_b   (b_reg[0]),
        .io_cin (carry_reg),
        .io_sum (fa_sum),
        .io_cout(fa_cout)
    );

    assign last_bit    = (cnt_reg == LAST_BIT);
    assign sum_shifted = {fa_sum, sum_reg[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (io_start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (io_start) begin
                        a_reg     <= zero_a(io_op) ? '0 : io_a;
                        b_reg     <= invert_b(io_op) ? ~io_b : io_b;
                        carry_reg <= invert_b(io_op);
                        cnt_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
                    sum_reg   <= sum_shifted;
                    carry_reg <= fa_cout;
                    a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        result_reg <= sum_shifted;
                        cout_reg   <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_busy   = (state_reg == ST_RUN);
    assign io_done   = (state_reg == ST_DONE);
    assign io_result = result_reg;
    assign io_cout   = cout_reg;
    assign io_neg    = result_reg[WIDTH-1];

endmodule
